// File: rtl/ray_logic_pkg.sv
// Shared types and helpers for the ray_logic_pipe bitwise datapath.
// Operation encoding and the per-bit operation evaluator live here.
package ray_logic_pkg;

    localparam int MAX_STAGES = 8;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } logic_op_t;

    // Single-bit evaluation; callers loop over the operand width.
    function automatic logic apply_op(
        input logic      a,
        input logic      b,
        input logic_op_t op
    );
        logic r;
        r = 1'b0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ray_pipe_stage.sv
// One valid/ready register slot of the ray_logic_pipe pipeline.
// Accepts a new beat whenever it is empty or its contents are being taken.
module ray_pipe_stage #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    input  logic [DW-1:0] up_data,
    output logic          up_ready,
    output logic          dn_valid,
    output logic [DW-1:0] dn_data,
    input  logic          dn_ready
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;
    logic          en;

    assign en       = !valid_q || dn_ready;
    assign up_ready = en;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

    // Load from upstream when enabled; bubbles leave the data untouched.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (en) begin
            valid_d = up_valid;
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    // Slot register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/ray_logic_pipe.sv
// Bitwise AND/OR/XOR/NAND unit with a STAGES-deep valid/ready pipeline.
// Optional handshake counters are enabled by RAY_LOGIC_PIPE_STATS_EN.
module ray_logic_pipe
    import ray_logic_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] prod,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
`ifdef RAY_LOGIC_PIPE_STATS_EN
    ,
    output logic [31:0]      stat_ops,
    output logic [31:0]      stat_zero
`endif
);

    localparam int DW = WIDTH + 1;

    logic [WIDTH-1:0]         res;
    logic                     res_zero;
    logic [STAGES:0]          vld;
    logic [STAGES:0]          take;
    logic [STAGES:0][DW-1:0]  dat;

    // Evaluate the selected operation bit by bit on the incoming operands.
    always_comb begin
        res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res[i] = apply_op(in1[i], in2[i], logic_op_t'(op));
        end
    end

    assign res_zero     = (res == '0);
    assign vld[0]       = in_valid;
    assign dat[0]       = {res_zero, res};
    assign take[STAGES] = out_ready;
    assign in_ready     = take[0];
    assign out_valid    = vld[STAGES];
    assign zero         = dat[STAGES][DW-1];
    assign prod         = dat[STAGES][WIDTH-1:0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        ray_pipe_stage #(
            .DW(DW)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (vld[k]),
            .up_data  (dat[k]),
            .up_ready (take[k]),
            .dn_valid (vld[k+1]),
            .dn_data  (dat[k+1]),
            .dn_ready (take[k+1])
        );
    end

`ifdef RAY_LOGIC_PIPE_STATS_EN
    logic [31:0] stat_ops_q;
    logic [31:0] stat_ops_d;
    logic [31:0] stat_zero_q;
    logic [31:0] stat_zero_d;

    // Count output handshakes, and those carrying a zero result.
    always_comb begin
        stat_ops_d  = stat_ops_q;
        stat_zero_d = stat_zero_q;
        if (out_valid && out_ready) begin
            stat_ops_d = stat_ops_q + 32'd1;
            if (zero) begin
                stat_zero_d = stat_zero_q + 32'd1;
            end
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops_q  <= '0;
            stat_zero_q <= '0;
        end else begin
            stat_ops_q  <= stat_ops_d;
            stat_zero_q <= stat_zero_d;
        end
    end

    assign stat_ops  = stat_ops_q;
    assign stat_zero = stat_zero_q;
`endif

endmodule

// File: tb/tb_ray_logic_pipe.sv
// Scoreboard bench for ray_logic_pipe (WIDTH=8, STAGES=2).
// Expected results are queued on input handshakes and popped on output ones.
module tb_ray_logic_pipe;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic [1:0]   op = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] prod;
    logic         zero;
    logic         out_valid;
    logic         out_ready = 1'b1;
`ifdef RAY_LOGIC_PIPE_STATS_EN
    logic [31:0]  stat_ops;
    logic [31:0]  stat_zero;
`endif

    int n_chk = 0;
    int n_fail = 0;
    logic [W:0] sb_q[$];
    int exp_ops = 0;
    int exp_zero = 0;
    bit prev_stall = 1'b0;
    logic [W:0] prev_out = '0;

    ray_logic_pipe #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in1       (in1),
        .in2       (in2),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef RAY_LOGIC_PIPE_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_zero (stat_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [1:0] o);
        case (o)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // Monitor: sample mid-cycle, i.e. the handshakes of the coming edge.
    always @(negedge clk) begin
        logic [W-1:0] r;
        logic [W:0]   e;
        if (rst) begin
            sb_q.delete();
            prev_stall = 1'b0;
            exp_ops = 0;
            exp_zero = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'({zero, prod}), 32'(prev_out));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_prod", 32'(prod), 32'(e[W-1:0]));
                    chk("sb_zero", 32'(zero), 32'(e[W]));
                    exp_ops++;
                    if (e[W]) exp_zero++;
                end
            end
            if (in_valid && in_ready) begin
                r = model(in1, in2, op);
                sb_q.push_back({(r == '0), r});
            end
            prev_stall = out_valid && !out_ready;
            prev_out = {zero, prod};
        end
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] o);
        bit acc;
        acc = 1'b0;
        in1 = a;
        in2 = b;
        op = o;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("drive_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_prod", 32'(prod), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency: result visible STAGES cycles after sampling.
        drive(8'hF0, 8'h3C, 2'd0);
        chk("lat_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_prod", 32'(prod), 32'h30);
        chk("lat_zero", 32'(zero), 32'd0);
        drain();

        // All four operations back to back, no bubbles.
        drive(8'hAA, 8'h0F, 2'd0);
        drive(8'hAA, 8'h0F, 2'd1);
        chk("ops_and", 32'(prod), 32'h0A);
        drive(8'hAA, 8'h0F, 2'd2);
        chk("ops_or", 32'(prod), 32'hAF);
        drive(8'hAA, 8'h0F, 2'd3);
        chk("ops_xor", 32'(prod), 32'hA5);
        @(posedge clk);
        #1;
        chk("ops_nand", 32'(prod), 32'hF5);
        chk("ops_valid", 32'(out_valid), 32'd1);
        drain();

        // Backpressure: two fit, third waits for the first drain.
        out_ready = 1'b0;
        in1 = 8'h11; in2 = 8'h22; op = 2'd1; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in1 = 8'hFF; in2 = 8'h0F; op = 2'd2;
        @(negedge clk);
        chk("bp_rdy2", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in1 = 8'h12; in2 = 8'h34; op = 2'd0;
        @(negedge clk);
        chk("bp_full", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_full2", 32'(in_ready), 32'd0);
        chk("bp_held", 32'(prod), 32'h33);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_same_cyc", 32'(in_ready), 32'd1);
        chk("bp_first", 32'(prod), 32'h33);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_second", 32'(prod), 32'hF0);
        @(posedge clk);
        #1;
        chk("bp_third", 32'(prod), 32'h10);
        drain();

        // Zero flag.
        drive(8'h55, 8'hAA, 2'd0);
        drive(8'h55, 8'hAA, 2'd3);
        chk("zf_prod", 32'(prod), 32'h00);
        chk("zf_zero", 32'(zero), 32'd1);
        @(posedge clk);
        #1;
        chk("zf_nand", 32'(prod), 32'hFF);
        chk("zf_nzero", 32'(zero), 32'd0);
        drain();

        // Random traffic with random backpressure.
        for (int i = 0; i < 200; i++) begin
            in1 = W'($urandom);
            in2 = ($urandom_range(0, 3) == 0) ? ~in1 : W'($urandom);
            op = 2'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

`ifdef RAY_LOGIC_PIPE_STATS_EN
        @(negedge clk);
        chk("stat_ops", stat_ops, 32'(exp_ops));
        chk("stat_zero", stat_zero, 32'(exp_zero));
        @(posedge clk);
        #1;
`endif

        // Asynchronous reset with two results buffered.
        out_ready = 1'b0;
        drive(8'h0F, 8'h0F, 2'd1);
        drive(8'hF0, 8'h0F, 2'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_prod", 32'(prod), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
`ifdef RAY_LOGIC_PIPE_STATS_EN
        chk("stat_ops_rst", stat_ops, 32'd0);
        chk("stat_zero_rst", stat_zero, 32'd0);
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("arst_stale", 32'(out_valid), 32'd0);
        end
        chk("sb_left", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ray_logic_pipe.md
Name: ray_logic_pipe

Overview:
- Parametrised successor to the team's two-input AND primitive.
- Generalised to W-bit operands, a selectable bitwise operation and a configurable-depth registered pipeline with valid/ready flow control.
- Sits between operand producers and result consumers in datapath test designs; one operation is accepted per clock when not stalled.

Parameters:
- WIDTH, 8, operand/result bit width (>=1)
- STAGES, 2, pipeline register depth = latency in cycles (1..8)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B
- op  input  2  operation: 0=AND, 1=OR, 2=XOR, 3=NAND
- in_valid  input  1  operands/op valid this cycle
- in_ready  output  1  block accepts this cycle
- prod  output  WIDTH  result
- zero  output  1  prod == 0
- out_valid  output  1  prod/zero valid
- out_ready  input  1  consumer accepts this cycle

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (rst). While rst=1, all stage valid bits, prod, zero and out_valid are 0. in_ready is 1 on the first edge after release.
- Transfer in: occurs when in_valid && in_ready. Result is computed combinationally from in1/in2/op and captured into stage 0; op is not carried further.
- Stage k: holds {valid_k, data_k}.
  - Stage k loads from stage k-1 when stage k is empty or stage k+1 is loading from it.
  - The last stage drains when out_valid && out_ready.
  - Each stage's enable = !valid_k || downstream_take_k.
  - Full throughput (1/clk) with out_ready held high.
- in_ready = !valid_0 || take_0. This is combinational through the stall chain; no combinational path from in_valid to in_ready.
- Latency: a transfer at edge N produces out_valid=1 after edge N+STAGES-1, i.e. visible STAGES cycles after in_valid was sampled.
- Stall: out_ready=0 with out_valid=1 holds prod/zero stable. Bubbles collapse, so up to STAGES results are buffered. in_ready drops only when every stage is full.
- Simultaneous drain and fill of a full pipe: both happen in the same cycle; no loss, no duplicate.
- zero is registered together with prod and computed at stage 0.
- Reset mid-operation: all in-flight results are discarded with no output beat. Results accepted before rst are never emitted.
- out_valid must never fall without a handshake (AXI-style stability). prod/zero must not change while out_valid && !out_ready.

Optional Feature:
- Macro: RAY_LOGIC_PIPE_STATS_EN.
- Defined: adds outputs stat_ops (32-bit, count of output handshakes) and stat_zero (32-bit, count of output handshakes with zero=1). Both reset to 0 and wrap modulo 2^32.
- Undefined: neither port nor counters exist; behaviour is otherwise identical.

Decomposition:
- Package ray_logic_pkg:
  - enum logic_op_t (OP_AND=0, OP_OR=1, OP_XOR=2, OP_NAND=3)
  - function apply_op(a, b, op)
  - localparam MAX_STAGES=8
- Sub-module ray_pipe_stage (parametrised by data width): one valid/ready register slot with its own enable logic. ray_logic_pipe instantiates STAGES of these in a generate loop, using named port connections.

Test Plan:
- Reset/latency:
  - Stimulus: rst pulse, then WIDTH=8, STAGES=2; in1=8'hF0, in2=8'h3C, op=AND, out_ready=1.
  - Required: out_valid rises 2 cycles after acceptance, prod=8'h30, zero=0.
- All ops:
  - Stimulus: in1=8'hAA, in2=8'h0F, op sequence 0,1,2,3 on back-to-back cycles.
  - Required: prod stream 8'h0A, 8'hAF, 8'hA5, 8'hF5 on consecutive cycles, no bubbles.
- Backpressure:
  - Stimulus: out_ready=0, issue 3 ops with STAGES=2.
  - Required: exactly 2 accepted, then in_ready=0; prod held. On out_ready=1, results drain in order and the third op is accepted in the same cycle as the first drain.
- Zero flag:
  - Stimulus: in1=8'h55, in2=8'hAA, op=AND.
  - Required: prod=0, zero=1.
  - With op=NAND: prod=8'hFF, zero=0.
- Async reset mid-flight:
  - Stimulus: assert rst between clock edges with 2 results buffered.
  - Required: out_valid=0 immediately (before the next edge). After release, no stale result appears.
- Stats (macro defined):
  - Stimulus: 5 handshakes, 2 of them with zero=1.
  - Required: stat_ops=5, stat_zero=2. After rst both read 0.
